// File: rtl/trace_buffer.sv
// Trace buffer: circular capture of retired-instruction records around a
// trigger, then oldest-first readout. Optional per-entry timestamps are
// enabled by defining TRACE_TIMESTAMP_EN.
module trace_buffer #(
   parameter int DATA_W = 96,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arm,
   input  logic [AW-1:0]     post_cnt,
   input  logic              trig,
   input  logic              cap_valid,
   input  logic [DATA_W-1:0] cap_data,
   output logic [1:0]        state,
   output logic              done,
   output logic              wrapped,
   output logic [AW:0]       count,
   input  logic              rd_req,
   output logic              rd_valid,
`ifdef TRACE_TIMESTAMP_EN
   output logic [TS_W-1:0]   rd_ts,
`endif
   output logic [DATA_W-1:0] rd_data
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      ARMED     = 2'b01,
      TRIGGERED = 2'b10,
      DONE      = 2'b11
   } state_t;

   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT1  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR1  = AW'(1);

   state_t              state_q;
   logic [AW-1:0]       wr_ptr_q;
   logic [AW:0]         count_q;
   logic                wrapped_q;
   logic [AW-1:0]       remaining_q;
   logic                rd_valid_q;
   logic [DATA_W-1:0]   rd_data_q;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_en;
   logic                rd_en;
   logic [AW-1:0]       rd_addr;

   // Write/read qualification; arm wins over everything in its cycle.
   // In DONE wr_ptr is frozen, so wr_ptr - count always points at the oldest
   // unread entry (count==DEPTH aliases to wr_ptr itself, the oldest slot).
   always_comb begin
      wr_en   = !arm && cap_valid && (state_q == ARMED || state_q == TRIGGERED);
      rd_en   = !arm && rd_req && (state_q == DONE) && (count_q != '0);
      rd_addr = wr_ptr_q - count_q[AW-1:0];
   end

   // Record storage; contents are never cleared, count defines what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= cap_data;
   end

   // Capture/readout FSM with pointer, occupancy and readout registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         wrapped_q   <= 1'b0;
         remaining_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else if (arm) begin
         state_q     <= ARMED;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         wrapped_q   <= 1'b0;
         remaining_q <= post_cnt;
         rd_valid_q  <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_data_q <= mem[rd_addr];
            count_q   <= count_q - CNT1;
         end
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR1;
            // A write into a full buffer overwrites the oldest entry.
            if (count_q == FULL) wrapped_q <= 1'b1;
            else                 count_q   <= count_q + CNT1;
         end
         case (state_q)
            ARMED: begin
               // The trigger-cycle sample is not part of the post count.
               if (trig) state_q <= (remaining_q != '0) ? TRIGGERED : DONE;
            end
            TRIGGERED: begin
               if (cap_valid) begin
                  remaining_q <= remaining_q - PTR1;
                  if (remaining_q == PTR1) state_q <= DONE;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] rd_ts_q;
   logic [TS_W-1:0] ts_mem [DEPTH];

   // Timestamp storage alongside each captured record.
   always_ff @(posedge clk) begin
      if (wr_en) ts_mem[wr_ptr_q] <= ts_q;
   end

   // Free-running timestamp restarted by arm; readout travels with rd_data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_q    <= '0;
         rd_ts_q <= '0;
      end else begin
         ts_q <= arm ? '0 : ts_q + TS_W'(1);
         if (rd_en) rd_ts_q <= ts_mem[rd_addr];
      end
   end

   assign rd_ts = rd_ts_q;
`endif

   assign state    = state_q;
   assign done     = (state_q == DONE);
   assign wrapped  = wrapped_q;
   assign count    = count_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer: expected read-out records are queued as
// stimulus is issued; a negedge monitor pops and compares on every rd_valid.
module tb_trace_buffer;

   localparam int DATA_W = 96;
   localparam int DEPTH  = 16;
   localparam int TS_W   = 16;
   localparam int AW     = 4;

   logic              clk;
   logic              reset;
   logic              arm;
   logic [AW-1:0]     post_cnt;
   logic              trig;
   logic              cap_valid;
   logic [DATA_W-1:0] cap_data;
   logic [1:0]        state;
   logic              done;
   logic              wrapped;
   logic [AW:0]       count;
   logic              rd_req;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]   rd_ts;
`endif

   trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk(clk), .reset(reset), .arm(arm), .post_cnt(post_cnt), .trig(trig),
      .cap_valid(cap_valid), .cap_data(cap_data), .state(state), .done(done),
      .wrapped(wrapped), .count(count), .rd_req(rd_req), .rd_valid(rd_valid),
`ifdef TRACE_TIMESTAMP_EN
      .rd_ts(rd_ts),
`endif
      .rd_data(rd_data)
   );

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [TS_W-1:0]   ts;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   rdv_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] d, input logic [TS_W-1:0] ts);
      exp_t e;
      e.d  = d;
      e.ts = ts;
      exp_q.push_back(e);
   endtask

   task automatic do_arm(input logic [AW-1:0] pc);
      arm = 1'b1;
      post_cnt = pc;
      tick();
      arm = 1'b0;
   endtask

   task automatic sample(input logic [DATA_W-1:0] d, input logic t);
      cap_valid = 1'b1;
      cap_data  = d;
      trig      = t;
      tick();
      cap_valid = 1'b0;
      trig      = 1'b0;
   endtask

   task automatic read_hold(input int n);
      rd_req = 1'b1;
      repeat (n) tick();
      rd_req = 1'b0;
      tick();
   endtask

   // Monitor: every presented read must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && rd_valid) begin
            rdv_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_rd_valid", 128'(rd_data), 128'hdead);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", 128'(rd_data), 128'(e.d));
`ifdef TRACE_TIMESTAMP_EN
               chk("rd_ts", 128'(rd_ts), 128'(e.ts));
`endif
            end
         end
      end
   end

   // Global bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      reset = 1'b0; arm = 1'b0; post_cnt = '0; trig = 1'b0;
      cap_valid = 1'b0; cap_data = '0; rd_req = 1'b0;
      #12;
      chk("rst_state", 128'(state), 128'h0);
      chk("rst_count", 128'(count), 128'h0);
      chk("rst_done", 128'(done), 128'h0);
      chk("rst_wrapped", 128'(wrapped), 128'h0);
      chk("rst_rd_valid", 128'(rd_valid), 128'h0);
      chk("rst_rd_data", 128'(rd_data), 128'h0);
      reset = 1'b1;
      tick();

      // IDLE ignores captures and reads
      sample(96'h77, 1'b1);
      rd_req = 1'b1; tick(); tick(); rd_req = 1'b0; tick();
      chk("idle_state", 128'(state), 128'h0);
      chk("idle_count", 128'(count), 128'h0);

      // Pre/post trigger capture, no wrap
      do_arm(4'd3);
      chk("armed_state", 128'(state), 128'h1);
      for (int i = 1; i <= 5; i++) sample(DATA_W'(i), 1'b0);
      sample(96'h6, 1'b1);
      chk("trig_state", 128'(state), 128'h2);
      sample(96'h7, 1'b0);
      sample(96'h8, 1'b0);
      chk("still_trig", 128'(state), 128'h2);
      sample(96'h9, 1'b0);
      chk("t1_state", 128'(state), 128'h3);
      chk("t1_done", 128'(done), 128'h1);
      chk("t1_count", 128'(count), 128'd9);
      chk("t1_wrapped", 128'(wrapped), 128'h0);
      for (int i = 1; i <= 9; i++) push(DATA_W'(i), '0);
      read_hold(9);
      chk("t1_count_after", 128'(count), 128'h0);

      // Wrap: 21 samples into 16 entries, immediate DONE with post_cnt=0
      do_arm(4'd0);
      for (int i = 1; i <= 20; i++) sample(DATA_W'(i), 1'b0);
      sample(96'h15, 1'b1);
      chk("t2_state", 128'(state), 128'h3);
      chk("t2_count", 128'(count), 128'd16);
      chk("t2_wrapped", 128'(wrapped), 128'h1);
      for (int i = 6; i <= 21; i++) push(DATA_W'(i), '0);
      read_hold(16);
      chk("t2_count_after", 128'(count), 128'h0);

      // Held rd_req beyond available entries
      do_arm(4'd1);
      sample(96'ha, 1'b0);
      sample(96'hb, 1'b1);
      sample(96'hc, 1'b0);
      chk("t3_count", 128'(count), 128'd3);
      push(96'ha, '0); push(96'hb, '0); push(96'hc, '0);
      base = rdv_cnt;
      read_hold(5);
      tick();
      chk("t3_valid_cycles", 128'(rdv_cnt - base), 128'd3);
      chk("t3_count_after", 128'(count), 128'h0);
      chk("t3_rd_valid_low", 128'(rd_valid), 128'h0);
      chk("t3_rd_data_hold", 128'(rd_data), 128'hc);

      // arm + trig together from IDLE, then arm during TRIGGERED
      reset = 1'b0; #2; reset = 1'b1;
      tick();
      arm = 1'b1; trig = 1'b1; post_cnt = 4'd2;
      tick();
      arm = 1'b0; trig = 1'b0;
      chk("t4_arm_trig", 128'(state), 128'h1);
      sample(96'h31, 1'b1);
      sample(96'h32, 1'b0);
      chk("t4_trig_state", 128'(state), 128'h2);
      chk("t4_trig_count", 128'(count), 128'd2);
      do_arm(4'd2);
      chk("t4_rearm_state", 128'(state), 128'h1);
      chk("t4_rearm_count", 128'(count), 128'h0);
      chk("t4_rearm_wrapped", 128'(wrapped), 128'h0);

      // Async reset during ARMED with 7 entries
      for (int i = 1; i <= 7; i++) sample(DATA_W'(i + 64), 1'b0);
      chk("t5_count7", 128'(count), 128'd7);
      #2 reset = 1'b0;
      #1;
      chk("t5_state", 128'(state), 128'h0);
      chk("t5_count", 128'(count), 128'h0);
      chk("t5_rd_valid", 128'(rd_valid), 128'h0);
      chk("t5_done", 128'(done), 128'h0);
      reset = 1'b1;
      tick();

`ifdef TRACE_TIMESTAMP_EN
      // Timestamps: first ARMED cycle is timestamp 0
      do_arm(4'd0);
      tick(); tick();
      sample(96'h41, 1'b0);
      tick(); tick();
      sample(96'h42, 1'b0);
      sample(96'h43, 1'b1);
      chk("t6_state", 128'(state), 128'h3);
      push(96'h41, 16'd2); push(96'h42, 16'd5); push(96'h43, 16'd6);
      read_hold(3);
`endif

      tick();
      chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
